pc_branch_ctrl: RTL and testbench



---
 rtl/definitions.sv | 34 +++
 rtl/branch_lut.sv | 52 +++++
 rtl/pc_branch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared opcode encodings, PC sequencer state and flag types for the core.
// The branch-condition helper resolves a branch opcode against stored flags.
package definitions;

  localparam logic [4:0] kADD = 5'h00;
  localparam logic [4:0] kCMP = 5'h05;
  localparam logic [4:0] kBE  = 5'h10;
  localparam logic [4:0] kBL  = 5'h11;
  localparam logic [4:0] kBG  = 5'h12;
  localparam logic [4:0] kBA  = 5'h13;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_t;

  typedef struct packed {
    logic co;
    logic lt;
    logic z;
  } flags_t;

  // Non-branch opcodes (including unknown ones) never resolve taken.
  function automatic logic branchCond(input logic [4:0] op, input flags_t f);
    logic taken;
    taken = 1'b0;
    case (op)
      kBE:     taken = f.z;
      kBL:     taken = f.lt;
      kBG:     taken = !f.z && !f.lt;
      kBA:     taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Constant branch-target ROM: imm selects an absolute PC (entry i = (i+1)*16).
// Only built when BRANCH_LUT_EN is defined.
`ifdef BRANCH_LUT_EN
module branch_lut #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic [LUT_AW-1:0] idx_i,
  output logic [PC_W-1:0]   target_o
);

  always_comb begin
    target_o = '0;
    case (32'(idx_i))
      0:  target_o = PC_W'(12'h010);
      1:  target_o = PC_W'(12'h020);
      2:  target_o = PC_W'(12'h030);
      3:  target_o = PC_W'(12'h040);
      4:  target_o = PC_W'(12'h050);
      5:  target_o = PC_W'(12'h060);
      6:  target_o = PC_W'(12'h070);
      7:  target_o = PC_W'(12'h080);
      8:  target_o = PC_W'(12'h090);
      9:  target_o = PC_W'(12'h0A0);
      10: target_o = PC_W'(12'h0B0);
      11: target_o = PC_W'(12'h0C0);
      12: target_o = PC_W'(12'h0D0);
      13: target_o = PC_W'(12'h0E0);
      14: target_o = PC_W'(12'h0F0);
      15: target_o = PC_W'(12'h100);
      16: target_o = PC_W'(12'h110);
      17: target_o = PC_W'(12'h120);
      18: target_o = PC_W'(12'h130);
      19: target_o = PC_W'(12'h140);
      20: target_o = PC_W'(12'h150);
      21: target_o = PC_W'(12'h160);
      22: target_o = PC_W'(12'h170);
      23: target_o = PC_W'(12'h180);
      24: target_o = PC_W'(12'h190);
      25: target_o = PC_W'(12'h1A0);
      26: target_o = PC_W'(12'h1B0);
      27: target_o = PC_W'(12'h1C0);
      28: target_o = PC_W'(12'h1D0);
      29: target_o = PC_W'(12'h1E0);
      30: target_o = PC_W'(12'h1F0);
      31: target_o = PC_W'(12'h200);
      default: target_o = '0;
    endcase
  end

endmodule
`endif

// File: rtl/pc_branch_ctrl.sv
// Program counter, start/run/halt sequencer and flag-based branch resolution.
// BRANCH_LUT_EN selects absolute LUT targets; otherwise targets are PC-relative.
module pc_branch_ctrl
  import definitions::*;
#(
  parameter int PC_W     = 10,
  parameter int LUT_AW   = 5,
  parameter int START_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic [4:0]        op,
  input  logic [LUT_AW-1:0] imm,
  input  logic              alu_co,
  input  logic              alu_lt,
  input  logic              alu_z,
  output logic [PC_W-1:0]   pc,
  output logic              flag_co,
  output logic              flag_lt,
  output logic              flag_z,
  output logic              branch_taken,
  output logic              running,
  output logic              done
);

  localparam logic [PC_W-1:0] kStartPc = PC_W'(START_PC);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  flags_t          flags_q, flags_d;
  logic [PC_W-1:0] pcInc;
  logic [PC_W-1:0] target;

  assign pcInc = pc_q + PC_W'(1);

`ifdef BRANCH_LUT_EN
  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) uBranchLut (
    .idx_i    (imm),
    .target_o (target)
  );
`else
  // Offset is sign-extended so a 5-bit field reaches -16..+15 around pc.
  assign target = pc_q + {{(PC_W-LUT_AW){imm[LUT_AW-1]}}, imm};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= kStartPc;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flags_d      = flags_q;
    branch_taken = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = kStartPc;
        end
      end
      RUN: begin
        if (op == kCMP) begin
          flags_d.z  = alu_z;
          flags_d.lt = alu_lt;
        end else if (op == kADD) begin
          flags_d.co = alu_co;
        end
        // Branches see only the stored flags, so a CMP lands one cycle later.
        if (!halt_req) begin
          branch_taken = branchCond(op, flags_q);
        end
        if (start) begin
          pc_d = kStartPc;
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (branch_taken) begin
          pc_d = target;
        end else begin
          pc_d = pcInc;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = kStartPc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign flag_co = flags_q.co;
  assign flag_lt = flags_q.lt;
  assign flag_z  = flags_q.z;
  assign running = (state_q == RUN);
  assign done    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed vector bench for pc_branch_ctrl: a vector table plus hand-written
// sequences for PC wrap and asynchronous reset in the middle of a cycle.
module tb_pc_branch_ctrl;
  import definitions::*;

  localparam logic [4:0] kNOP = 5'h02;
  localparam logic [4:0] kUNK = 5'h1F;

  typedef struct {
    logic       start;
    logic       halt;
    logic [4:0] op;
    logic [4:0] imm;
    logic       co;
    logic       lt;
    logic       z;
    logic       exBt;
    logic [9:0] exPc;
    logic [2:0] exFlags;
    logic       exRun;
    logic       exDone;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       halt_req;
  logic [4:0] op;
  logic [4:0] imm;
  logic       alu_co;
  logic       alu_lt;
  logic       alu_z;
  logic [9:0] pc;
  logic       flag_co;
  logic       flag_lt;
  logic       flag_z;
  logic       branch_taken;
  logic       running;
  logic       done;

  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[64];
  int   nVec = 0;
  logic [9:0] p;

  always #5 clk = ~clk;

  pc_branch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt_req     (halt_req),
    .op           (op),
    .imm          (imm),
    .alu_co       (alu_co),
    .alu_lt       (alu_lt),
    .alu_z        (alu_z),
    .pc           (pc),
    .flag_co      (flag_co),
    .flag_lt      (flag_lt),
    .flag_z       (flag_z),
    .branch_taken (branch_taken),
    .running      (running),
    .done         (done)
  );

  function automatic logic [9:0] tgt(input logic [9:0] pcv, input logic [4:0] im);
`ifdef BRANCH_LUT_EN
    return ({5'b0, im} + 10'd1) << 4;
`else
    return pcv + {{5{im[4]}}, im};
`endif
  endfunction

  task automatic addVec(input logic s, input logic h, input logic [4:0] o,
                        input logic [4:0] im, input logic c, input logic l,
                        input logic zz, input logic bt, input logic [9:0] npc,
                        input logic [2:0] fl, input logic r, input logic d);
    vecs[nVec] = '{s, h, o, im, c, l, zz, bt, npc, fl, r, d};
    nVec++;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic [4:0] o,
                               input logic [4:0] im, input logic c, input logic l,
                               input logic zz);
    start    = s;
    halt_req = h;
    op       = o;
    imm      = im;
    alu_co   = c;
    alu_lt   = l;
    alu_z    = zz;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nopCycle();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, kNOP, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: each row drives one cycle, bt is checked before the edge,
    // pc/flags/state after it. p tracks the expected pc.
    p = 10'd0;
    addVec(0, 0, kBA,  5'd0,  0, 0, 0, 0, p, 3'b000, 0, 0);
    addVec(1, 0, kNOP, 5'd0,  0, 0, 0, 0, p, 3'b000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      p = p + 10'd1;
      addVec(0, 0, kNOP, 5'd0, 0, 0, 0, 0, p, 3'b000, 1, 0);
    end
    p = p + 10'd1;
    addVec(0, 0, kCMP, 5'd0,  0, 0, 1, 0, p, 3'b001, 1, 0);
    p = tgt(p, 5'd3);
    addVec(0, 0, kBE,  5'd3,  0, 0, 0, 1, p, 3'b001, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kBL,  5'd3,  0, 0, 0, 0, p, 3'b001, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kCMP, 5'd0,  1, 0, 0, 0, p, 3'b000, 1, 0);
    p = tgt(p, 5'd2);
    addVec(0, 0, kBG,  5'd2,  0, 0, 0, 1, p, 3'b000, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kCMP, 5'd0,  0, 1, 0, 0, p, 3'b010, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kBG,  5'd2,  0, 0, 0, 0, p, 3'b010, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kADD, 5'd0,  1, 0, 1, 0, p, 3'b110, 1, 0);
    p = tgt(p, 5'b11100);
    addVec(0, 0, kBL,  5'b11100, 0, 0, 0, 1, p, 3'b110, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kUNK, 5'd0,  0, 0, 1, 0, p, 3'b110, 1, 0);
    p = p + 10'd1;
    addVec(0, 0, kBE,  5'd5,  0, 0, 0, 0, p, 3'b110, 1, 0);
    p = 10'd0;
    addVec(1, 1, kNOP, 5'd0,  0, 0, 0, 0, p, 3'b110, 1, 0);
    addVec(0, 0, kNOP, 5'd0,  0, 0, 0, 0, 10'd1, 3'b110, 1, 0);
    addVec(0, 0, kNOP, 5'd0,  0, 0, 0, 0, 10'd2, 3'b110, 1, 0);
    addVec(0, 0, kBA,  5'b11100, 0, 0, 0, 1, tgt(10'd2, 5'b11100), 3'b110, 1, 0);
    addVec(1, 0, kNOP, 5'd0,  0, 0, 0, 0, 10'd0, 3'b110, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      addVec(0, 0, kNOP, 5'd0, 0, 0, 0, 0, 10'(i), 3'b110, 1, 0);
    end
    addVec(0, 1, kBA,  5'd1,  0, 0, 0, 0, 10'd7, 3'b110, 0, 1);
    addVec(0, 0, kBA,  5'd1,  0, 0, 0, 0, 10'd7, 3'b110, 0, 1);
    addVec(0, 0, kCMP, 5'd0,  0, 0, 1, 0, 10'd7, 3'b110, 0, 1);
    addVec(1, 0, kNOP, 5'd0,  0, 0, 0, 0, 10'd0, 3'b110, 1, 0);
    addVec(0, 0, kNOP, 5'd0,  0, 0, 0, 0, 10'd1, 3'b110, 1, 0);

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, kNOP, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_pc",    32'(pc), 32'd0);
    checkOutput("reset_flags", 32'({flag_co, flag_lt, flag_z}), 32'd0);
    checkOutput("reset_run",   32'(running), 32'd0);
    checkOutput("reset_done",  32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < nVec; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].op, vecs[i].imm,
                    vecs[i].co, vecs[i].lt, vecs[i].z);
      #1;
      checkOutput($sformatf("v%0d_bt", i), 32'(branch_taken), 32'(vecs[i].exBt));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exPc));
      checkOutput($sformatf("v%0d_flags", i), 32'({flag_co, flag_lt, flag_z}),
                  32'(vecs[i].exFlags));
      checkOutput($sformatf("v%0d_run", i), 32'(running), 32'(vecs[i].exRun));
      checkOutput($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exDone));
    end

    // PC wrap from the top of the address space.
    for (int i = 0; i < 1100 && pc != 10'h3FF; i++) nopCycle();
    checkOutput("wrap_reach", 32'(pc), 32'h3FF);
    nopCycle();
    checkOutput("wrap_pc", 32'(pc), 32'h000);

    // Reset between edges while running at pc 0x055.
    for (int i = 0; i < 200 && pc != 10'h055; i++) nopCycle();
    checkOutput("mid_reach", 32'(pc), 32'h055);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_pc",    32'(pc), 32'd0);
    checkOutput("mid_flags", 32'({flag_co, flag_lt, flag_z}), 32'd0);
    checkOutput("mid_run",   32'(running), 32'd0);
    checkOutput("mid_done",  32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nopCycle();
      checkOutput($sformatf("idle%0d_pc", i), 32'(pc), 32'd0);
      checkOutput($sformatf("idle%0d_run", i), 32'(running), 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, kNOP, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("restart_run", 32'(running), 32'd1);
    nopCycle();
    checkOutput("restart_pc", 32'(pc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
